// File: rtl/uart_bus_pkg.sv
// Shared constants for the memory-mapped UART responder: register map,
// STATUS/CTRL bit positions, TX FSM encodings and the busy-wait timeout.
package uart_bus_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_RXDATA = 4'h8;
    localparam logic [3:0] OFF_CTRL   = 4'hC;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_TX_IDLE     = 2;
    localparam int ST_RX_VALID    = 3;
    localparam int ST_RX_OVERRUN  = 4;
    localparam int ST_TX_OVERFLOW = 5;

    localparam int CTRL_RX_CLR   = 0;
    localparam int CTRL_ERR_CLR  = 1;
    localparam int CTRL_TX_FLUSH = 2;

    localparam logic [1:0] TX_IDLE      = 2'd0;
    localparam logic [1:0] TX_START     = 2'd1;
    localparam logic [1:0] TX_WAIT_BUSY = 2'd2;
    localparam logic [1:0] TX_WAIT_DONE = 2'd3;

    localparam int         TIMEOUT_CYCLES = 16;
    localparam logic [3:0] TIMEOUT_LAST   = 4'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic tx_overflow;
        logic rx_overrun;
        logic rx_valid;
        logic tx_idle;
        logic tx_empty;
        logic tx_full;
    } status_t;

    function automatic logic [31:0] status_word(input status_t st);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[ST_TX_FULL]     = st.tx_full;
        w[ST_TX_EMPTY]    = st.tx_empty;
        w[ST_TX_IDLE]     = st.tx_idle;
        w[ST_RX_VALID]    = st.rx_valid;
        w[ST_RX_OVERRUN]  = st.rx_overrun;
        w[ST_TX_OVERFLOW] = st.tx_overflow;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; writes to a full FIFO are dropped
// and a flush wins over any same-cycle push.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               dout
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(1'b0);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == CNT_ZERO);
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full & ~flush;
    assign do_pop_s  = pop & ~empty;

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= PTR_ONE ^ PTR_ONE;
            rd_ptr_r <= PTR_ONE ^ PTR_ONE;
            count_r  <= CNT_ZERO;
        end else if (flush) begin
            wr_ptr_r <= PTR_ONE ^ PTR_ONE;
            rd_ptr_r <= PTR_ONE ^ PTR_ONE;
            count_r  <= CNT_ZERO;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_bus_responder.sv
// CPU-bus slave exposing a UART as four registers: TX FIFO with a start/busy
// handshake FSM, and a single-byte RX holding register with overrun detection.
module uart_bus_responder
    import uart_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] HADDR,
    input  logic        MemWrite,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        sel,
    output logic        send_tx,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        rx_ready_clr
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel_s, wr_s, tx_push_s, ctrl_wr_s, pop_s, tx_idle_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [CW-1:0] tx_count_s;
    logic [7:0]    fifo_dout_s;
    logic [1:0]    state_r;
    logic [3:0]    tmo_r;
    logic          send_tx_r, rx_ready_clr_r, rx_prev_r;
    logic [7:0]    tx_data_r, rx_hold_r;
    logic          rx_valid_r, rx_overrun_r, tx_overflow_r;
    logic          rx_event_s, rx_valid_eff_s;
    logic          unused_hwdata_s;
    status_t       status_s;
    logic [31:0]   hrdata_s;

    assign sel_s     = (HADDR[31:4] == BASE_ADDR[31:4]);
    assign wr_s      = sel_s & MemWrite;
    assign tx_push_s = wr_s & (HADDR[3:0] == OFF_TXDATA);
    assign ctrl_wr_s = wr_s & (HADDR[3:0] == OFF_CTRL);
    assign pop_s     = (state_r == TX_IDLE) & ~fifo_empty_s & ~tx_busy;
    assign tx_idle_s = (state_r == TX_IDLE) & (tx_count_s == {CW{1'b0}});

    // A CTRL rx-clear in the capture cycle frees the holding register first,
    // so the arriving byte is taken rather than flagged as an overrun.
    assign rx_event_s     = rx_ready & ~rx_prev_r;
    assign rx_valid_eff_s = rx_valid_r & ~(ctrl_wr_s & HWDATA[CTRL_RX_CLR]);
    assign unused_hwdata_s = ^HWDATA[31:8];

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push_s),
        .pop   (pop_s),
        .flush (ctrl_wr_s & HWDATA[CTRL_TX_FLUSH]),
        .din   (HWDATA[7:0]),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (tx_count_s),
        .dout  (fifo_dout_s)
    );

    // Transmit sequencer: pop, pulse start, then wait for busy (or time out)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= TX_IDLE;
            tx_data_r <= 8'h00;
            send_tx_r <= 1'b0;
            tmo_r     <= 4'h0;
        end else begin
            send_tx_r <= 1'b0;
            case (state_r)
                TX_IDLE: begin
                    if (pop_s) begin
                        state_r   <= TX_START;
                        tx_data_r <= fifo_dout_s;
                        send_tx_r <= 1'b1;
                    end
                end
                TX_START: begin
                    state_r <= TX_WAIT_BUSY;
                    tmo_r   <= 4'h0;
                end
                TX_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_r <= TX_WAIT_DONE;
                    end else if (tmo_r == TIMEOUT_LAST) begin
                        state_r <= TX_IDLE;
                    end else begin
                        tmo_r <= tmo_r + 4'h1;
                    end
                end
                TX_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_r <= TX_IDLE;
                    end
                end
                default: state_r <= TX_IDLE;
            endcase
        end
    end

    // Receive capture, sticky error flags and receiver acknowledge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_prev_r      <= 1'b0;
            rx_hold_r      <= 8'h00;
            rx_valid_r     <= 1'b0;
            rx_overrun_r   <= 1'b0;
            tx_overflow_r  <= 1'b0;
            rx_ready_clr_r <= 1'b0;
        end else begin
            rx_prev_r      <= rx_ready;
            rx_ready_clr_r <= rx_event_s;
            if (rx_event_s && !rx_valid_eff_s) begin
                rx_hold_r  <= rx_data;
                rx_valid_r <= 1'b1;
            end else begin
                rx_valid_r <= rx_valid_eff_s;
            end
            if (rx_event_s && rx_valid_eff_s) begin
                rx_overrun_r <= 1'b1;
            end else if (ctrl_wr_s && HWDATA[CTRL_ERR_CLR]) begin
                rx_overrun_r <= 1'b0;
            end
            if (tx_push_s && fifo_full_s) begin
                tx_overflow_r <= 1'b1;
            end else if (ctrl_wr_s && HWDATA[CTRL_ERR_CLR]) begin
                tx_overflow_r <= 1'b0;
            end
        end
    end

    assign status_s = '{tx_overflow: tx_overflow_r, rx_overrun: rx_overrun_r,
                        rx_valid: rx_valid_r, tx_idle: tx_idle_s,
                        tx_empty: fifo_empty_s, tx_full: fifo_full_s};

    // Side-effect-free register read mux
    always_comb begin
        hrdata_s = 32'h0000_0000;
        if (sel_s) begin
            case (HADDR[3:0])
                OFF_STATUS: hrdata_s = status_word(status_s);
                OFF_RXDATA: hrdata_s = {24'h00_0000, rx_hold_r};
                default:    hrdata_s = 32'h0000_0000;
            endcase
        end else begin
            hrdata_s = 32'h0000_0000;
        end
    end

    assign HRDATA       = hrdata_s;
    assign sel          = sel_s;
    assign send_tx      = send_tx_r;
    assign tx_data      = tx_data_r;
    assign rx_ready_clr = rx_ready_clr_r;

endmodule

// File: doc/uart_bus_responder.md
UART_BUS_RESPONDER -- requirements
Module: uart_bus_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1001_0000, the 16-byte-aligned base of the UART register window.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the TX FIFO depth; it must be a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port HADDR, input, 32 bits: CPU data address.
REQ-006 SHALL have port MemWrite, input, 1 bit: CPU store strobe, sampled on the same cycle as HADDR.
REQ-007 SHALL have port HWDATA, input, 32 bits: CPU store data.
REQ-008 SHALL have port HRDATA, output, 32 bits: combinational read data.
REQ-009 SHALL have port sel, output, 1 bit: high when HADDR[31:4] equals BASE_ADDR[31:4].
REQ-010 SHALL have port send_tx, output, 1 bit: one-cycle start pulse to the UART transmitter.
REQ-011 SHALL have port tx_data, output, 8 bits: byte presented to the transmitter.
REQ-012 SHALL have port tx_busy, input, 1 bit: transmitter busy level.
REQ-013 SHALL have port rx_ready, input, 1 bit: receiver byte-ready level.
REQ-014 SHALL have port rx_data, input, 8 bits: received byte, valid while rx_ready is high.
REQ-015 SHALL have port rx_ready_clr, output, 1 bit: one-cycle pulse that clears the receiver ready flag.

Function
REQ-016 SHALL define the register map by offset HADDR[3:0]: 0x0 TXDATA (write only), 0x4 STATUS (read only), 0x8 RXDATA (read only), 0xC CTRL (write only).
REQ-017 SHALL have no side effects on reads; HRDATA SHALL be 0 when sel=0, for write-only offsets, and for unmapped offsets.
REQ-018 SHALL define STATUS as: bit0 tx_full, bit1 tx_empty, bit2 tx_idle (FSM in IDLE and FIFO empty), bit3 rx_valid, bit4 rx_overrun, bit5 tx_overflow; bits 31:6 read as 0.
REQ-019 SHALL return {24'b0, rx_hold} on RXDATA reads.
REQ-020 SHALL push HWDATA[7:0] into the TX FIFO on a write to TXDATA (sel=1 and MemWrite=1); the pushed entry is visible in STATUS on the next cycle.
REQ-021 SHALL drop a TXDATA write when the FIFO is full (fullness taken from the pre-edge count), set tx_overflow, and leave the FIFO contents unchanged, even if a pop occurs in the same cycle.
REQ-022 SHALL leave the FIFO count unchanged when a push and a pop occur in the same cycle on a non-full FIFO, with first-in-first-out order preserved.
REQ-023 SHALL act on a CTRL write, per bit: bit0 clears rx_valid; bit1 clears rx_overrun and tx_overflow; bit2 flushes the TX FIFO to empty.
REQ-024 SHALL let a flush during a transmission end that byte normally; bytes pushed in the same cycle as a flush are discarded.
REQ-025 SHALL implement the TX FSM states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-026 SHALL move IDLE to START when the FIFO is non-empty and tx_busy=0; this transition pops the FIFO and registers the byte into tx_data.
REQ-027 SHALL assert send_tx for exactly one cycle in START, then move to WAIT_BUSY.
REQ-028 SHALL move WAIT_BUSY to WAIT_DONE when tx_busy=1, or to IDLE if tx_busy stays 0 for 16 cycles (timeout; the byte counts as sent).
REQ-029 SHALL move WAIT_DONE to IDLE when tx_busy=0.
REQ-030 SHALL hold tx_data stable from START until the next pop.
REQ-031 SHALL detect an RX event as a rising edge of rx_ready, using a registered previous value.
REQ-032 SHALL, on an RX event with rx_valid=0, load rx_hold with rx_data, set rx_valid, and pulse rx_ready_clr on the next cycle.
REQ-033 SHALL, on an RX event with rx_valid=1, discard the new byte, set rx_overrun, and still pulse rx_ready_clr.
REQ-034 SHALL give capture priority over a same-cycle CTRL bit0 write: the new byte loads, rx_valid stays 1, and rx_overrun is not set.

Reset
REQ-035 SHALL, while reset=1, drive send_tx, rx_ready_clr and tx_data to 0, set the FSM to IDLE, empty the FIFO, clear rx_hold, rx_valid, rx_overrun, tx_overflow, the timeout counter and the rx_ready edge register.
REQ-036 SHALL, on reset during any FSM state, abandon that state with no further send_tx pulse.

Structure
REQ-037 SHALL place the register offsets, STATUS and CTRL bit indices, FSM state encodings and the 16-cycle timeout constant in a shared package, uart_bus_pkg.
REQ-038 SHALL implement the TX FIFO as one sub-module, uart_tx_fifo, with push, pop, flush, full, empty, count and dout.

Verification
REQ-039 SHALL cover: write 0x41 to BASE+0x0 with tx_busy idle -> send_tx pulses once, 2 cycles later, with tx_data=0x41; model tx_busy high for 10 cycles -> STATUS reads 0x6 after tx_busy falls.
REQ-040 SHALL cover: 5 writes 0x01..0x05 while tx_busy is held at 1 -> STATUS bit0=1 and bit5=1; release tx_busy -> exactly 0x01..0x04 are sent in order.
REQ-041 SHALL cover: rx_data=0x5A with rx_ready rising -> one rx_ready_clr pulse, RXDATA reads 0x5A, STATUS bit3=1; a second byte 0x33 before acknowledge -> RXDATA stays 0x5A and bit4=1.
REQ-042 SHALL cover: a write of 0x3 to CTRL in the same cycle as an rx_ready rising edge for 0x77 -> RXDATA reads 0x77, bit3=1, bit4=0.
REQ-043 SHALL cover: tx_busy never rises after send_tx -> the FSM returns to IDLE 16 cycles after WAIT_BUSY entry and the next queued byte starts.
REQ-044 SHALL cover: reset asserted in WAIT_DONE with 2 bytes queued -> all outputs are 0 and STATUS reads 0x6 immediately, asynchronously.
